// File: rtl/cam_pkg.sv
// Shared definitions for the camera receive path: FSM states, frame geometry
// defaults and the pixel-pair bit layout used by the frame buffer words.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VSYNC     = 3'd1,
        ST_WAIT_LINE = 3'd2,
        ST_LINE      = 3'd3,
        ST_DONE      = 3'd4
    } cam_state_e;

    localparam int DEF_WIDTH       = 12;
    localparam int DEF_TRUELINE    = 1080;
    localparam int DEF_TRUEPIXEL   = 1920;
    localparam int WORDS_PER_LINE  = DEF_TRUEPIXEL / 2;
    localparam int WORDS_PER_FRAME = DEF_TRUELINE * DEF_TRUEPIXEL / 2;

    // Slot index of each pixel inside a packed word: first pixel lands in the upper half.
    localparam int FIRST_PIX_SLOT  = 1;
    localparam int SECOND_PIX_SLOT = 0;

    function automatic int words_per_frame(input int lines, input int pixels);
        return (lines * pixels) / 2;
    endfunction

endpackage

// File: rtl/cam_pix_pack.sv
// Pixel-pair packer: holds the even pixel of each pair and emits a packed word on
// the odd pixel, or a zero-padded flush word at the end of an odd-length line.
module cam_pix_pack
    import cam_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic               iclk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [WIDTH-1:0]   pix,
    input  logic               pix_valid,
    input  logic               line_end,
    output logic [2*WIDTH-1:0] word,
    output logic               strobe
);

    logic [WIDTH-1:0] hold_r;
    logic             phase_r;

    // Half-word hold register and pair phase
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r  <= {WIDTH{1'b0}};
            phase_r <= 1'b0;
        end else if (clear) begin
            hold_r  <= {WIDTH{1'b0}};
            phase_r <= 1'b0;
        end else if (pix_valid) begin
            if (!phase_r) begin
                hold_r <= pix;
            end else begin
                hold_r <= hold_r;
            end
            phase_r <= ~phase_r;
        end else if (line_end) begin
            phase_r <= 1'b0;
        end else begin
            phase_r <= phase_r;
        end
    end

    // Word assembly; a pending half at line end is flushed with a zero low half
    always_comb begin
        word   = {(2*WIDTH){1'b0}};
        strobe = 1'b0;
        if (clear) begin
            strobe = 1'b0;
        end else if (pix_valid) begin
            strobe = phase_r;
            word[FIRST_PIX_SLOT*WIDTH +: WIDTH]  = hold_r;
            word[SECOND_PIX_SLOT*WIDTH +: WIDTH] = pix;
        end else if (line_end) begin
            strobe = phase_r;
            word[FIRST_PIX_SLOT*WIDTH +: WIDTH]  = hold_r;
            word[SECOND_PIX_SLOT*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        end else begin
            strobe = 1'b0;
        end
    end

endmodule

// File: rtl/cam_rx_packer.sv
// Camera receive framer: registers sync/line_valid/data, tracks frame and line
// geometry, and drives a word-addressed write stream of packed pixel pairs.
module cam_rx_packer
    import cam_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int TRUELINE  = 1080,
    parameter int TRUEPIXEL = 1920,
    parameter int ADDR_W    = 20
) (
    input  logic               iclk,
    input  logic               rst_n,
    input  logic               sync_i,
    input  logic               line_valid_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [2*WIDTH-1:0] wr_data,
    output logic               frame_start,
    output logic               frame_done,
    output logic [10:0]        line_idx,
    output logic               err_line_len,
    output logic               err_frame_lines
);

    localparam int WC_W  = ADDR_W + 1;
    localparam int CNT_W = 16;
    localparam logic [WC_W-1:0]  WPF_C        = WC_W'(words_per_frame(TRUELINE, TRUEPIXEL));
    localparam logic [CNT_W-1:0] TRUEPIXEL_C  = CNT_W'(TRUEPIXEL);
    localparam logic [10:0]      LAST_LINE_C  = 11'(TRUELINE - 1);

    logic               sync_r, sync_d_r, lv_r, lv_d_r;
    logic [WIDTH-1:0]   data_r;
    logic               sync_rise_s, lv_rise_s, last_line_s;

    cam_state_e         state_r, state_s;
    logic               start_s, restart_s, accept_s, line_end_s, done_s, defer_s;
    logic               done_late_r;

    logic [2*WIDTH-1:0] pack_word_s;
    logic               pack_stb_s;

    logic [CNT_W-1:0]   pix_cnt_r;
    logic [WC_W-1:0]    wcnt_r;
    logic               wr_en_r, frame_start_r, frame_done_r;
    logic               err_line_len_r, err_frame_lines_r;
    logic [ADDR_W-1:0]  wr_addr_r;
    logic [2*WIDTH-1:0] wr_data_r;
    logic [10:0]        line_idx_r;

    // Input capture plus one extra stage for edge detection
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r   <= 1'b0;
            sync_d_r <= 1'b0;
            lv_r     <= 1'b0;
            lv_d_r   <= 1'b0;
            data_r   <= {WIDTH{1'b0}};
        end else begin
            sync_r   <= sync_i;
            sync_d_r <= sync_r;
            lv_r     <= line_valid_i;
            lv_d_r   <= lv_r;
            data_r   <= data_i;
        end
    end

    assign sync_rise_s = sync_r & ~sync_d_r;
    assign lv_rise_s   = lv_r & ~lv_d_r;
    assign last_line_s = (line_idx_r == LAST_LINE_C);

    // FSM state register
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_s    = state_r;
        start_s    = 1'b0;
        restart_s  = 1'b0;
        accept_s   = 1'b0;
        line_end_s = 1'b0;
        done_s     = 1'b0;
        defer_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sync_rise_s) begin
                    start_s = 1'b1;
                    state_s = ST_VSYNC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_VSYNC: begin
                if (!sync_r) begin
                    state_s = ST_WAIT_LINE;
                end else begin
                    state_s = ST_VSYNC;
                end
            end
            ST_WAIT_LINE: begin
                if (sync_rise_s) begin
                    start_s   = 1'b1;
                    restart_s = 1'b1;
                    state_s   = ST_VSYNC;
                end else if (lv_rise_s) begin
                    accept_s = 1'b1;
                    state_s  = ST_LINE;
                end else begin
                    state_s = ST_WAIT_LINE;
                end
            end
            ST_LINE: begin
                if (sync_rise_s) begin
                    start_s   = 1'b1;
                    restart_s = 1'b1;
                    state_s   = ST_VSYNC;
                end else if (lv_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_LINE;
                end else begin
                    // line_valid fell; an odd line emits its flush word this edge,
                    // so frame_done waits one cycle longer in that case
                    line_end_s = 1'b1;
                    if (last_line_s) begin
                        done_s  = ~pix_cnt_r[0];
                        defer_s = pix_cnt_r[0];
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_WAIT_LINE;
                    end
                end
            end
            ST_DONE: begin
                done_s  = done_late_r;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    cam_pix_pack #(
        .WIDTH(WIDTH)
    ) u_pack (
        .iclk      (iclk),
        .rst_n     (rst_n),
        .clear     (start_s),
        .pix       (data_r),
        .pix_valid (accept_s),
        .line_end  (line_end_s),
        .word      (pack_word_s),
        .strobe    (pack_stb_s)
    );

    // Counters, error flags and registered write port
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r           <= 1'b0;
            wr_addr_r         <= {ADDR_W{1'b0}};
            wr_data_r         <= {(2*WIDTH){1'b0}};
            wcnt_r            <= {WC_W{1'b0}};
            pix_cnt_r         <= {CNT_W{1'b0}};
            line_idx_r        <= 11'd0;
            frame_start_r     <= 1'b0;
            frame_done_r      <= 1'b0;
            done_late_r       <= 1'b0;
            err_line_len_r    <= 1'b0;
            err_frame_lines_r <= 1'b0;
        end else begin
            wr_en_r       <= 1'b0;
            frame_start_r <= start_s;
            frame_done_r  <= done_s;
            done_late_r   <= defer_s;
            if (start_s) begin
                wr_addr_r         <= {ADDR_W{1'b0}};
                wcnt_r            <= {WC_W{1'b0}};
                pix_cnt_r         <= {CNT_W{1'b0}};
                line_idx_r        <= 11'd0;
                err_line_len_r    <= 1'b0;
                err_frame_lines_r <= restart_s;
            end else begin
                // Words past the end of the frame buffer are dropped and flagged
                if (pack_stb_s) begin
                    if (wcnt_r < WPF_C) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= wcnt_r[ADDR_W-1:0];
                        wr_data_r <= pack_word_s;
                        wcnt_r    <= wcnt_r + WC_W'(1);
                    end else begin
                        err_line_len_r <= 1'b1;
                    end
                end
                if (accept_s) begin
                    if (pix_cnt_r != {CNT_W{1'b1}}) begin
                        pix_cnt_r <= pix_cnt_r + 16'd1;
                    end
                end
                if (line_end_s) begin
                    pix_cnt_r <= {CNT_W{1'b0}};
                    if (pix_cnt_r != TRUEPIXEL_C) begin
                        err_line_len_r <= 1'b1;
                    end
                    if (!last_line_s) begin
                        line_idx_r <= line_idx_r + 11'd1;
                    end
                end
            end
        end
    end

    assign wr_en           = wr_en_r;
    assign wr_addr         = wr_addr_r;
    assign wr_data         = wr_data_r;
    assign frame_start     = frame_start_r;
    assign frame_done      = frame_done_r;
    assign line_idx        = line_idx_r;
    assign err_line_len    = err_line_len_r;
    assign err_frame_lines = err_frame_lines_r;

endmodule

// File: tb/tb_cam_rx_packer.sv
// Randomized bench for cam_rx_packer (4 lines x 8 pixels) against a queue-based
// frame model; every strobe is popped from the expected word queue.
module tb_cam_rx_packer;

    localparam int W   = 12;
    localparam int TL  = 4;
    localparam int TP  = 8;
    localparam int AW  = 6;
    localparam int WPF = TL * TP / 2;

    logic            iclk, rst_n, sync_i, line_valid_i;
    logic [W-1:0]    data_i;
    logic            wr_en, frame_start, frame_done, err_line_len, err_frame_lines;
    logic [AW-1:0]   wr_addr;
    logic [2*W-1:0]  wr_data;
    logic [10:0]     line_idx;

    cam_rx_packer #(
        .WIDTH(W), .TRUELINE(TL), .TRUEPIXEL(TP), .ADDR_W(AW)
    ) dut (
        .iclk(iclk), .rst_n(rst_n), .sync_i(sync_i), .line_valid_i(line_valid_i),
        .data_i(data_i), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_start(frame_start), .frame_done(frame_done), .line_idx(line_idx),
        .err_line_len(err_line_len), .err_frame_lines(err_frame_lines)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    typedef struct { int addr; int data; } word_t;
    word_t exp_q[$];

    int  m_addr = 0, m_lines = 0, m_done = 0, ramp_n = 0;
    bit  m_active = 0, m_err_len = 0, m_err_lines = 0, m_drop = 0;
    int  n_done = 0, n_start = 0, n_wr = 0, last_wr_cyc = 0, fs_cyc = 0, sync_cyc = 0;
    int  obs [0:63];
    int  obs_cyc [0:63];
    int  a0_cyc, c1_cyc, saved, p_prev, nl;
    int  lens [6] = '{8, 8, 8, 7, 9, 6};

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int pack(input int hi, input int lo);
        return (hi << W) | lo;
    endfunction

    task automatic m_push(input int w);
        if (m_addr < WPF) begin
            exp_q.push_back('{m_addr, w});
            m_addr++;
        end else begin
            m_err_len = 1;
            m_drop    = 1;
        end
    endtask

    task automatic m_sync();
        m_err_lines = m_active;
        m_active  = 1;
        m_addr    = 0;
        m_lines   = 0;
        m_err_len = 0;
        m_drop    = 0;
        ramp_n    = 0;
    endtask

    // Output monitor: every strobe must match the next expected word
    always @(negedge iclk) begin
        if (wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("spurious_wr_en", 1, 0);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end
            obs[wr_addr]     = int'(wr_data);
            obs_cyc[wr_addr] = cyc;
            last_wr_cyc      = cyc;
        end
        if (frame_start) begin
            n_start++;
            fs_cyc = cyc;
        end
        if (frame_done) begin
            n_done++;
            if (!m_drop) check("frame_done_latency", cyc - last_wr_cyc, 1);
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic do_sync();
        repeat (4) tick();
        sync_i   = 1'b1;
        sync_cyc = cyc;
        m_sync();
        repeat (3) tick();
        sync_i = 1'b0;
        repeat (2) tick();
    endtask

    // mode 0: frame ramp, 1: random, 2: values 1..len
    task automatic do_line(input int len, input int gap, input int mode);
        int  prev;
        bit  act;
        act  = m_active;
        prev = 0;
        line_valid_i = 1'b1;
        for (int i = 0; i < len; i++) begin
            int v;
            case (mode)
                0: begin v = ramp_n % 4096; ramp_n++; end
                1: v = int'($urandom_range(0, 4095));
                default: v = i + 1;
            endcase
            data_i = W'(v);
            if (act) begin
                if (i % 2 == 1) m_push(pack(prev, v));
                else prev = v;
            end
            tick();
        end
        line_valid_i = 1'b0;
        data_i = W'($urandom);
        if (act) begin
            if (len % 2 == 1) m_push(pack(prev, 0));
            if (len != TP) m_err_len = 1;
            m_lines++;
            if (m_lines == TL) begin
                m_active = 0;
                m_done++;
            end
        end
        repeat (gap) tick();
    endtask

    task automatic end_frame();
        repeat (6) tick();
        check("words_pending", exp_q.size(), 0);
        check("err_line_len", err_line_len, m_err_len);
        check("err_frame_lines", err_frame_lines, m_err_lines);
        check("frame_done_count", n_done, m_done);
        check("line_idx", line_idx, (m_lines >= TL) ? TL - 1 : m_lines);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_line_idx"}, line_idx, 0);
        check({tag, "_err_line_len"}, err_line_len, 0);
        check({tag, "_err_frame_lines"}, err_frame_lines, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; sync_i = 1'b0; line_valid_i = 1'b0; data_i = '0;
        repeat (3) @(posedge iclk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Pixels before any sync are ignored
        do_line(6, 2, 1);
        do_line(8, 2, 1);
        check("idle_wr_count", n_wr, 0);

        // Nominal ramp frame
        saved = n_start;
        do_sync();
        check("frame_start_count", n_start, saved + 1);
        check("frame_start_latency", fs_cyc - sync_cyc, 2);
        a0_cyc = cyc;
        for (int l = 0; l < TL; l++) do_line(TP, 1, 0);
        end_frame();
        check("first_word_latency", obs_cyc[0] - a0_cyc, 3);
        check("ramp_word3", obs[3], 32'h006007);
        check("ramp_word15", obs[15], 32'h01E01F);
        check("nominal_line_idx", line_idx, 3);

        // Back-to-back random frame; addresses restart at 0
        do_sync();
        for (int l = 0; l < TL; l++) do_line(TP, int'($urandom_range(1, 3)), 1);
        end_frame();

        // Short line of 7 pixels valued 1..7
        do_sync();
        do_line(TP, 1, 1);
        c1_cyc = cyc;
        do_line(7, 1, 2);
        do_line(TP, 2, 1);
        do_line(TP, 1, 1);
        end_frame();
        check("short_line_flush_word", obs[7], 32'h007000);
        check("flush_latency", obs_cyc[7] - c1_cyc, 9);
        check("short_line_err", err_line_len, 1);

        // Sync after two lines aborts the frame
        do_sync();
        do_line(TP, 1, 1);
        do_line(TP, 1, 1);
        saved = n_done;
        do_sync();
        check("abort_err_frame_lines", err_frame_lines, 1);
        check("abort_no_done", n_done, saved);
        for (int l = 0; l < TL; l++) do_line(TP, 1, 1);
        end_frame();

        // Overlong last line overruns the frame buffer
        do_sync();
        for (int l = 0; l < TL - 1; l++) do_line(TP, 1, 1);
        do_line(10, 1, 1);
        end_frame();
        check("overflow_err", err_line_len, 1);

        // Reset mid-line
        do_sync();
        do_line(TP, 1, 1);
        line_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            int v;
            v = int'($urandom_range(0, 4095));
            data_i = W'(v);
            if (i % 2 == 1) m_push(pack(p_prev, v));
            else p_prev = v;
            tick();
        end
        @(negedge iclk);
        #1;
        rst_n = 1'b0;
        line_valid_i = 1'b0;
        exp_q.delete();
        m_active = 0; m_lines = 0; m_err_len = 0; m_err_lines = 0; m_drop = 0;
        #1;
        check_all_zero("midreset");
        repeat (3) @(posedge iclk);
        #1;
        rst_n = 1'b1;
        saved = n_wr;
        do_line(TP, 2, 1);
        check("post_reset_no_wr", n_wr, saved);
        do_sync();
        for (int l = 0; l < TL; l++) do_line(TP, 1, 1);
        end_frame();

        // Random geometry, including aborted frames
        for (int f = 0; f < 8; f++) begin
            do_sync();
            nl = int'($urandom_range(1, TL));
            for (int l = 0; l < nl; l++)
                do_line(lens[$urandom_range(0, 5)], int'($urandom_range(1, 3)), 1);
            end_frame();
        end

        repeat (5) tick();
        check("final_pending", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
